alu_serial: RTL
===============

# alu_serial

Bit-serial N-bit ALU sequencer that drives the team's 1-bit ALU slice, `alu1bit`, one bit per clock, LSB first. It carries the slice's carry between bits in a flip-flop. Operands and opcode arrive through a valid/ready request port. The finished N-bit result and carry leave through a valid/ready response port. It is the upstream controller for the 1-bit slice and is intended for area-limited datapaths where one slice replaces a full ripple array.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range is 2 to 64.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_a`  in  WIDTH  operand A.
- `req_b`  in  WIDTH  operand B.
- `req_op`  in  2  opcode: 00 NOR, 01 XOR, 10 ADD (A+B), 11 SUB (A−B).
- `res_valid`  out  1  result present; high only in DONE.
- `res_ready`  in  1  consumer takes the result.
- `res_s`  out  WIDTH  result.
- `res_cout`  out  1  carry out of the MSB for ADD/SUB; 0 for NOR/XOR. For SUB, 1 means no borrow (A ≥ B unsigned).

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch `req_a`, `req_b` and `req_op` into internal shift registers.
  - Load the carry flop with `req_op[0] & req_op[1]`: 1 for SUB, 0 otherwise.
  - Clear the bit index and go to RUN.
- **RUN**
  - Each cycle, feed bit 0 of the A/B shift registers, the carry flop and `op` into one `alu1bit` instance.
  - Shift the slice output `s` into the result register from the MSB end.
  - Shift A and B right by one, store the slice `cout` into the carry flop, and increment the index.
  - When the index reaches WIDTH−1, this cycle processes the last bit and the next state is DONE.
  - Changes on the `req_*` inputs during RUN have no effect.
- **DONE**
  - `res_valid`=1.
  - `res_s` holds the full result; `res_cout` holds the carry flop (forced to 0 when `op[1]`=0).
  - All `res_*` outputs stay stable until `res_ready`=1, then the FSM returns to IDLE.
- Arithmetic is modulo 2^WIDTH. SUB is computed as A + ~B + 1 through the slice's subtract path.
- Any request arriving in RUN or DONE is not accepted, because `req_ready` is 0. The requester must hold it.

## Timing
- **Reset values** (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `req_ready`=1, `res_valid`=0, `res_s`=0, `res_cout`=0.
  - The carry flop, index and shift registers are cleared.
- Reset asserted mid-RUN or mid-DONE aborts the operation: the result is discarded and no `res_valid` pulse is produced.
- **Latency:** if the request is accepted at edge E0, `res_valid` rises after edge E0+WIDTH, giving exactly WIDTH RUN cycles.
- **Throughput:** one operation per WIDTH+2 cycles at best, i.e. back-to-back with `res_ready` held high.
- `res_ready` seen high in the first DONE cycle returns the FSM to IDLE at the next edge. `req_ready` is then high one cycle later; there is no same-cycle DONE→RUN bypass.
- `res_ready` asserted while not in DONE is ignored.

## Configuration
- **Macro:** `ALU_SERIAL_FLAGS_EN`.
- **Defined:** two extra outputs, each valid with `res_valid` and reset to 0.
  - `res_zero` (1 bit): 1 when `res_s`==0.
  - `res_ovf` (1 bit): two's-complement overflow for ADD/SUB, equal to the carry into the MSB XOR the carry out of the MSB. It is 0 for NOR/XOR. The carry into the MSB is captured during the last RUN cycle.
- **Undefined:** these ports and their logic do not exist. All other behaviour is identical.

## Test plan
- **Reset:** reset then idle → `req_ready`=1, `res_valid`=0, `res_s`=0. Assert `rst_n`=0 in the 3rd RUN cycle of an ADD → IDLE next cycle, and no `res_valid` ever appears for that request.
- **ADD, WIDTH=8:** A=8'h7F, B=8'h01 → after 8 cycles `res_s`=8'h80, `res_cout`=0; with flags, `res_ovf`=1, `res_zero`=0. A=8'hFF, B=8'h01 → `res_s`=8'h00, `res_cout`=1, `res_zero`=1, `res_ovf`=0.
- **SUB:** A=8'h05, B=8'h07 → `res_s`=8'hFE, `res_cout`=0. A=8'h05, B=8'h05 → `res_s`=8'h00, `res_cout`=1, `res_zero`=1. A=8'h80, B=8'h01 → `res_s`=8'h7F, `res_ovf`=1.
- **Logic ops:** NOR A=8'hF0, B=8'h0C → `res_s`=8'h03, `res_cout`=0. XOR A=8'hA5, B=8'hFF → `res_s`=8'h5A, `res_cout`=0.
- **Handshake:**
  - Hold `res_ready`=0 for 5 DONE cycles → `res_s`/`res_cout` are stable and `req_ready`=0 throughout.
  - Toggle `req_a`/`req_b` during RUN → result is unchanged.
  - Two back-to-back requests with `res_ready`=1 → the second is accepted exactly WIDTH+2 cycles after the first.
- **Random regression:** 1000 random operands and ops at WIDTH=8 and WIDTH=2 → every result matches the reference model: `res_s` = op(A,B) mod 2^WIDTH, plus `res_cout` and the flags.

Source files
------------

// File: rtl/alu_serial_if.sv
// Request/response bundle for alu_serial: operands and opcode in, result and carry out, both valid/ready.
// The res_zero/res_ovf flag wires exist only when ALU_SERIAL_FLAGS_EN is defined.
interface alu_serial_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_s;
  logic             res_cout;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             res_zero;
  logic             res_ovf;

  modport master (
    output req_valid, req_a, req_b, req_op, res_ready,
    input  req_ready, res_valid, res_s, res_cout, res_zero, res_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, res_ready,
    output req_ready, res_valid, res_s, res_cout, res_zero, res_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, res_ready,
    input  req_ready, res_valid, res_s, res_cout
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, res_ready,
    output req_ready, res_valid, res_s, res_cout
  );
`endif
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU over one alu1bit slice, LSB first: WIDTH RUN cycles, result held in DONE until res_ready.
// Requests stall (req_ready=0) outside IDLE. Flags res_zero/res_ovf are built when ALU_SERIAL_FLAGS_EN is defined.
module alu1bit (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic [1:0] i_op,
  output logic       o_s,
  output logic       o_cout
);
  logic w_b;

  // SUB inverts B; the +1 comes from the carry preloaded by the sequencer
  assign w_b = i_b ^ (i_op == 2'b11);

  always_comb begin
    o_s    = 1'b0;
    o_cout = 1'b0;
    case (i_op)
      2'b00:   o_s = ~(i_a | i_b);
      2'b01:   o_s = i_a ^ i_b;
      default: begin
        o_s    = i_a ^ w_b ^ i_cin;
        o_cout = (i_a & w_b) | (i_cin & (i_a ^ w_b));
      end
    endcase
  end
endmodule

module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_serial_if.slave   bus
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [1:0]       r_op;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic             w_last;
  logic             w_req_ready;
  logic             w_res_valid;
  logic             w_s;
  logic             w_cout;

  assign w_last = (r_idx == IW'(WIDTH - 1));

  alu1bit u_slice (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .i_op   (r_op),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic r_cmsb;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_s   <= '0;
      r_op  <= 2'b00;
      r_c   <= 1'b0;
      r_idx <= '0;
`ifdef ALU_SERIAL_FLAGS_EN
      r_cmsb <= 1'b0;
`endif
    end else if (r_state == S_IDLE && bus.req_valid) begin
      r_a   <= bus.req_a;
      r_b   <= bus.req_b;
      r_op  <= bus.req_op;
      r_c   <= bus.req_op[0] & bus.req_op[1];
      r_idx <= '0;
    end else if (r_state == S_RUN) begin
      // result fills from the MSB end so bit 0 lands in place after WIDTH shifts
      r_s   <= {w_s, r_s[WIDTH-1:1]};
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_cout;
      r_idx <= r_idx + 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
      if (w_last) r_cmsb <= r_c;
`endif
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_s     = r_s;
  assign bus.res_cout  = r_op[1] & r_c;

`ifdef ALU_SERIAL_FLAGS_EN
  assign bus.res_zero = w_res_valid & ~(|r_s);
  assign bus.res_ovf  = w_res_valid & r_op[1] & (r_cmsb ^ r_c);
`endif
endmodule
